// File: rtl/value_store_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : value_store_writer_if
// Brief    : Value-beat input, memory-write and completion handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface value_store_writer_if;
   logic [543:0] s_value_data;
   logic         s_value_valid;
   logic         s_value_ready;
   logic [15:0]  m_wr_addr;
   logic [511:0] m_wr_data;
   logic [63:0]  m_wr_strb;
   logic         m_wr_valid;
   logic         m_wr_ready;
   logic [15:0]  m_done_pointer;
   logic [15:0]  m_done_len;
   logic         m_done_valid;
   logic         m_done_ready;

   // Environment side: produces value beats and accepts writes/completions.
   modport master (
      output s_value_data, s_value_valid, m_wr_ready, m_done_ready,
      input  s_value_ready, m_wr_addr, m_wr_data, m_wr_strb, m_wr_valid,
             m_done_pointer, m_done_len, m_done_valid
   );

   // Writer side.
   modport slave (
      input  s_value_data, s_value_valid, m_wr_ready, m_done_ready,
      output s_value_ready, m_wr_addr, m_wr_data, m_wr_strb, m_wr_valid,
             m_done_pointer, m_done_len, m_done_valid
   );
endinterface
`default_nettype wire

// File: rtl/value_store_writer.sv
`default_nettype none
// ============================================================================
// Module   : value_store_writer
// Brief    : Splits a variable-length value into 64-byte memory writes and
//            emits one completion record once its last write has transferred.
// Revision : 1.0 - initial release
// ============================================================================
module value_store_writer (
   input  wire logic            clk,
   input  wire logic            rst_n,
   value_store_writer_if.slave  bus,
   output logic [15:0]          err_count
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] C_ERR_MAX  = 16'hFFFF;
   localparam logic [63:0] C_STRB_ALL = {64{1'b1}};

   state_t       r_state;
   logic [15:0]  r_base;
   logic [15:0]  r_len;
   logic [10:0]  r_beats;
   logic [10:0]  r_index;
   logic [15:0]  r_err_count;
   logic         r_wr_valid;
   logic [15:0]  r_wr_addr;
   logic [511:0] r_wr_data;
   logic [63:0]  r_wr_strb;
   logic         r_done_valid;
   logic [15:0]  r_done_pointer;
   logic [15:0]  r_done_len;

   logic [15:0]  w_in_ptr;
   logic [15:0]  w_in_len;
   logic [511:0] w_in_data;
   logic         w_s_ready;
   logic         w_s_fire;
   logic         w_wr_fire;
   logic         w_is_hdr;
   logic         w_data_beat;
   logic         w_err;
   logic [10:0]  w_hdr_beats;
   logic [15:0]  w_cur_len;
   logic [15:0]  w_cur_base;
   logic [10:0]  w_cur_beats;
   logic [10:0]  w_cur_index;
   logic         w_last;
   logic [63:0]  w_strb;

   assign w_in_ptr  = bus.s_value_data[543:528];
   assign w_in_len  = bus.s_value_data[527:512];
   assign w_in_data = bus.s_value_data[511:0];

   // A beat is only taken when the output register is free or draining now.
   assign w_s_ready = rst_n && (r_state == ST_IDLE || r_state == ST_WRITE) &&
                      (!r_wr_valid || bus.m_wr_ready);
   assign w_s_fire  = bus.s_value_valid && w_s_ready;
   assign w_wr_fire = r_wr_valid && bus.m_wr_ready;

   assign w_is_hdr    = (r_state == ST_IDLE) && (w_in_len != 16'd0);
   assign w_data_beat = w_s_fire && (w_is_hdr || r_state == ST_WRITE);
   assign w_err       = w_s_fire &&
                        (((r_state == ST_IDLE) && (w_in_len == 16'd0)) ||
                         ((r_state == ST_WRITE) && ((w_in_len != 16'd0) || (w_in_ptr != r_base))));

   // ceil(len/64): whole 64-byte blocks plus one if a partial tail exists
   assign w_hdr_beats = {1'b0, w_in_len[15:6]} + {10'd0, |w_in_len[5:0]};

   // The header beat is itself the first data beat, so it uses live fields.
   assign w_cur_len   = w_is_hdr ? w_in_len    : r_len;
   assign w_cur_base  = w_is_hdr ? w_in_ptr    : r_base;
   assign w_cur_beats = w_is_hdr ? w_hdr_beats : r_beats;
   assign w_cur_index = w_is_hdr ? 11'd0       : r_index;
   assign w_last      = (w_cur_index == (w_cur_beats - 11'd1));
   assign w_strb      = (w_last && (w_cur_len[5:0] != 6'd0)) ?
                        ((64'd1 << w_cur_len[5:0]) - 64'd1) : C_STRB_ALL;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_base         <= 16'd0;
         r_len          <= 16'd0;
         r_beats        <= 11'd0;
         r_index        <= 11'd0;
         r_err_count    <= 16'd0;
         r_wr_valid     <= 1'b0;
         r_wr_addr      <= 16'd0;
         r_wr_data      <= 512'd0;
         r_wr_strb      <= 64'd0;
         r_done_valid   <= 1'b0;
         r_done_pointer <= 16'd0;
         r_done_len     <= 16'd0;
      end else begin
         if (w_wr_fire) begin
            r_wr_valid <= 1'b0;
         end
         if (w_data_beat) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= w_cur_base + {5'd0, w_cur_index};
            r_wr_data  <= w_in_data;
            r_wr_strb  <= w_strb;
            r_index    <= w_cur_index + 11'd1;
         end
         if (w_err && (r_err_count != C_ERR_MAX)) begin
            r_err_count <= r_err_count + 16'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_s_fire && w_is_hdr) begin
                  r_base  <= w_in_ptr;
                  r_len   <= w_in_len;
                  r_beats <= w_hdr_beats;
                  r_state <= w_last ? ST_DRAIN : ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (w_s_fire && w_last) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Only the final beat can be pending here.
               if (w_wr_fire) begin
                  r_done_valid   <= 1'b1;
                  r_done_pointer <= r_base;
                  r_done_len     <= r_len;
                  r_state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.m_done_ready) begin
                  r_done_valid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.s_value_ready  = w_s_ready;
   assign bus.m_wr_valid     = r_wr_valid;
   assign bus.m_wr_addr      = r_wr_addr;
   assign bus.m_wr_data      = r_wr_data;
   assign bus.m_wr_strb      = r_wr_strb;
   assign bus.m_done_valid   = r_done_valid;
   assign bus.m_done_pointer = r_done_pointer;
   assign bus.m_done_len     = r_done_len;
   assign err_count          = r_err_count;
endmodule
`default_nettype wire
